// File: rtl/mem_split_arb2.sv
// Two-master split-bus arbiter with round-robin grant and a read tag FIFO.
// Read responses return in order and route to the master that issued them.
module mem_split_arb2 #(
   parameter int RD_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        arst_n_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_bi,
   input  logic [3:0]  m0_be_bi,
   input  logic [31:0] m0_wdata_bi,
   output logic        m0_ack_o,
   output logic        m0_resp_o,
   output logic [31:0] m0_rdata_bo,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_bi,
   input  logic [3:0]  m1_be_bi,
   input  logic [31:0] m1_wdata_bi,
   output logic        m1_ack_o,
   output logic        m1_resp_o,
   output logic [31:0] m1_rdata_bo,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_bo,
   output logic [3:0]  s_be_bo,
   output logic [31:0] s_wdata_bo,
   input  logic        s_ack_i,
   input  logic        s_resp_i,
   input  logic [31:0] s_rdata_bi,
   output logic        err_o
);

   localparam int AW = $clog2(RD_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(RD_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      HOLD0,
      HOLD1
   } state_t;

   state_t          state_q;
   logic            last_q;
   logic            win;
   logic            grant;
   logic            sel_req;
   logic            sel_we;
   logic            accept;
   logic            push;
   logic            pop;
   logic            tag_full;
   logic            head;
   logic [AW-1:0]   wptr_q;
   logic [AW-1:0]   rptr_q;
   logic [CW-1:0]   cnt_q;
   logic            tag_q [RD_DEPTH];
   logic            err_q;

   always_comb begin
      win = 1'b0;
      if (m0_req_i && m1_req_i)
         win = ~last_q;
      else if (m1_req_i)
         win = 1'b1;
   end

   always_comb begin
      grant = win;
      case (state_q)
         HOLD0:   grant = 1'b0;
         HOLD1:   grant = 1'b1;
         default: grant = win;
      endcase
   end

   assign sel_req    = grant ? m1_req_i    : m0_req_i;
   assign sel_we     = grant ? m1_we_i     : m0_we_i;
   assign s_we_o     = sel_we;
   assign s_addr_bo  = grant ? m1_addr_bi  : m0_addr_bi;
   assign s_be_bo    = grant ? m1_be_bi    : m0_be_bi;
   assign s_wdata_bo = grant ? m1_wdata_bi : m0_wdata_bi;

   // A pop in the same cycle frees a slot, so a full FIFO can still take a read.
   assign pop      = s_resp_i & (cnt_q != '0);
   assign tag_full = (cnt_q == FULL_CNT) & ~pop;

   assign s_req_o = arst_n_i & sel_req & ~(~sel_we & tag_full);
   assign accept  = s_req_o & s_ack_i;
   assign push    = accept & ~sel_we;

   assign m0_ack_o = accept & ~grant;
   assign m1_ack_o = accept & grant;

   assign head        = tag_q[rptr_q];
   assign m0_resp_o   = pop & ~head;
   assign m1_resp_o   = pop & head;
   assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
   assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;
   assign err_o       = err_q;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         if (accept)
            last_q <= grant;
         case (state_q)
            IDLE: begin
               if (s_req_o && !s_ack_i)
                  state_q <= grant ? HOLD1 : HOLD0;
            end
            HOLD0: begin
               if (!m0_req_i || accept)
                  state_q <= IDLE;
            end
            HOLD1: begin
               if (!m1_req_i || accept)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push)
            wptr_q <= wptr_q + AW'(1);
         if (pop)
            rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
         if (s_resp_i && (cnt_q == '0))
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         tag_q[wptr_q] <= grant;
   end

endmodule

// File: doc/mem_split_arb2.md
MEM_SPLIT_ARB2 -- requirements
Module: mem_split_arb2

Interface
REQ-001 SHALL have parameter RD_DEPTH, default 4, meaning the maximum number of outstanding read transactions; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port arst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have master ports m0_req_i / m1_req_i  input  1  request from master 0 and master 1.
REQ-005 SHALL have m0_we_i / m1_we_i  input  1  write enable; 1 = write, 0 = read.
REQ-006 SHALL have m0_addr_bi / m1_addr_bi  input  32  address.
REQ-007 SHALL have m0_be_bi / m1_be_bi  input  4  byte enables.
REQ-008 SHALL have m0_wdata_bi / m1_wdata_bi  input  32  write data.
REQ-009 SHALL have m0_ack_o / m1_ack_o  output  1  request accepted.
REQ-010 SHALL have m0_resp_o / m1_resp_o  output  1  read data valid.
REQ-011 SHALL have m0_rdata_bo / m1_rdata_bo  output  32  read data.
REQ-012 SHALL have slave side s_req_o, s_we_o (1), s_addr_bo (32), s_be_bo (4), s_wdata_bo (32) as outputs, and s_ack_i (1), s_resp_i (1), s_rdata_bi (32) as inputs, all with split-bus semantics.
REQ-013 SHALL have err_o  output  1  sticky flag set by an orphan response.

Function
REQ-014 SHALL implement a split bus: a transfer is accepted in the cycle where req and ack are both high; a read returns exactly one resp pulse with rdata in a later cycle; writes produce no resp.
REQ-015 SHALL use grant FSM states IDLE, HOLD0 and HOLD1; the slave-side outputs SHALL be a combinational mux of the granted master (the state's master in HOLDx, the arbitration winner in IDLE).
REQ-016 SHALL arbitrate in IDLE round-robin using a 1-bit last-winner register: with both masters requesting, the master that did not win last wins; with one master requesting, that master wins.
REQ-017 SHALL, when a presented request gets s_ack_i=0, move to HOLDx for the winning master x and keep that grant until s_ack_i=1; no switching mid-handshake.
REQ-018 SHALL return from HOLDx to IDLE on acceptance, and also return to IDLE if m<x>_req_i drops before acceptance.
REQ-019 SHALL drive mx_ack_o = s_ack_i & s_req_o & (grant==x); the non-granted master's ack SHALL be 0.
REQ-020 SHALL update the last-winner register on every accepted transfer, read or write.
REQ-021 SHALL push the granted master ID into a tag FIFO of depth RD_DEPTH on each accepted read.
REQ-022 SHALL pop the tag FIFO on s_resp_i=1 and route the response as mx_resp_o = s_resp_i for the head ID, mx_rdata_bo = s_rdata_bi for the head ID, and 0 on the other master's outputs.
REQ-023 SHALL, with the tag FIFO full, suppress s_req_o for granted reads; writes SHALL still pass.
REQ-024 SHALL treat the FIFO as not full when a pop occurs in the same cycle; simultaneous push and pop keeps the occupancy unchanged.
REQ-025 SHALL, on s_resp_i=1 with the FIFO empty, assert no master resp, perform no pop, and set err_o, which holds until reset.
REQ-026 SHALL add no latency: the request path and the response path are both combinational, 0 cycles.
REQ-027 SHALL, on wrap-around, wrap the FIFO read and write pointers modulo RD_DEPTH, with occupancy tracked by a counter of clog2(RD_DEPTH)+1 bits.

Reset
REQ-028 SHALL, on arst_n_i=0, immediately force the FSM to IDLE, the last winner to 1 (so master 0 wins first), the FIFO to empty and err_o to 0.
REQ-029 SHALL, during reset, drive all ack and resp outputs to 0; rdata outputs SHALL be 0 whenever the matching resp is 0.
REQ-030 SHALL discard outstanding read tags on reset mid-operation; a later s_resp_i is an orphan and sets err_o.

Verification
REQ-031 SHALL cover: both masters issue a read with s_ack_i=1 constantly -> accept order m0, m1, m0, m1; responses A then B route m0 gets A, m1 gets B.
REQ-032 SHALL cover: m1 reads with s_ack_i=0 for 3 cycles while m0 requests -> grant held on m1, m0_ack_o=0 throughout, m1 accepted on cycle 4.
REQ-033 SHALL cover: RD_DEPTH=4 with 4 reads outstanding, then a 5th read and a write -> read blocked (s_req_o=0), write accepted; after one resp, the read is accepted in that same cycle.
REQ-034 SHALL cover: s_resp_i=1 with no outstanding reads -> no mx_resp_o asserted, err_o=1 and held.
REQ-035 SHALL cover: 2 reads outstanding, arst_n_i pulsed low, then s_resp_i=1 -> no master resp, err_o=1.
REQ-036 SHALL cover: m0 drops req while in HOLD0 -> FSM returns to IDLE, m1 is granted the next cycle.
